// File: rtl/aes_req_sched_pkg.sv
// aes_sched_pkg: shared definitions for the AES request scheduler.
//   state_t        FSM state encoding (3 bits; codes 6 and 7 are unused)
//   BYTES_PER_MSG  ciphertext bytes emitted per message
//   PT_W           plaintext / ciphertext width
//   clog2()        elaboration-time log2 used to check the tag width
package aes_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_LOAD = 3'd2,
    ST_ENC  = 3'd3,
    ST_SEND = 3'd4,
    ST_STOP = 3'd5
  } state_t;

  localparam int BYTES_PER_MSG = 16;
  localparam int PT_W          = 128;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_req_sched_if.sv
// aes_req_sched_if: requester, AES core and output FIFO signals of the scheduler.
//   slave  modport: scheduler side (inputs start/req/pt_in/core_ct/core_rdy/fifo_afull)
//   master modport: environment side (drives the scheduler inputs)
interface aes_req_sched_if
  import aes_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int CH_W = 2
);
  logic                 start;
  logic [NREQ-1:0]      req;
  logic [PT_W*NREQ-1:0] pt_in;
  logic [NREQ-1:0]      gnt;
  logic                 core_load;
  logic [PT_W-1:0]      core_pt;
  logic [PT_W-1:0]      core_ct;
  logic                 core_rdy;
  logic                 fifo_afull;
  logic                 wr_en;
  logic [7:0]           data_out;
  logic [CH_W-1:0]      tag_out;
  logic                 busy;
  logic                 done;
  logic                 err_timeout;

  modport slave (
    input  start, req, pt_in, core_ct, core_rdy, fifo_afull,
    output gnt, core_load, core_pt, wr_en, data_out, tag_out, busy, done, err_timeout
  );

  modport master (
    output start, req, pt_in, core_ct, core_rdy, fifo_afull,
    input  gnt, core_load, core_pt, wr_en, data_out, tag_out, busy, done, err_timeout
  );
endinterface

// File: rtl/aes_req_sched_rr_arbiter.sv
// rr_arbiter: NREQ-wide round-robin picker.
//   req      in   request vector
//   upd      in   grant taken this cycle; advance pointer past pick_idx
//   pick_vld out  some request is set
//   pick_idx out  first set request scanning rr_ptr, rr_ptr+1, ... mod NREQ
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int CH_W = 2
) (
  input  logic            clk,
  input  logic            rst_h,
  input  logic [NREQ-1:0] req,
  input  logic            upd,
  output logic            pick_vld,
  output logic [CH_W-1:0] pick_idx
);
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;

  // Scan from the farthest offset down so the closest request to rr_ptr
  // is the last one written and therefore wins.
  always_comb begin
    int j;
    j        = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = (int'(rr_ptr_q) + i) % NREQ;
      if (req[j]) begin
        pick_vld = 1'b1;
        pick_idx = CH_W'(j);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (upd && pick_vld) begin
      rr_ptr_d = (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_h) begin
    if (rst_h) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
endmodule

// File: rtl/aes_req_sched.sv
// aes_req_sched: round-robin scheduler sharing one AES core among NREQ requesters.
//   clk, rst_h   clock and asynchronous active-high reset
//   bus (slave)  start/req/pt_in from requesters, gnt back; core_load/core_pt to
//                the core, core_ct/core_rdy from it; wr_en/data_out/tag_out to the
//                output FIFO with fifo_afull backpressure; busy/done/err_timeout status.
// Each message: ARB (grant + latch plaintext), LOAD (core strobe), ENC (wait for
// core_rdy), SEND (16 bytes, ct[7:0] first). A run ends after MAX_NUM messages.
// Optional macro AES_SCHED_TIMEOUT_EN adds an ENC watchdog of TIMEOUT_CYC cycles
// that abandons the message and raises sticky err_timeout; otherwise ENC waits
// indefinitely and err_timeout is tied low.
module aes_req_sched
  import aes_sched_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int CH_W        = 2,
  parameter int MAX_NUM     = 4000,
  parameter int TIMEOUT_CYC = 1023
) (
  input logic             clk,
  input logic             rst_h,
  aes_req_sched_if.slave  bus
);
  if (CH_W != clog2(NREQ)) begin : g_bad_ch_w
    $error("aes_req_sched: CH_W must equal clog2(NREQ)");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("aes_req_sched: TIMEOUT_CYC must fit the 16-bit watchdog");
  end

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              core_load_q, core_load_d;
  logic [PT_W-1:0]   pt_q, pt_d;
  logic [PT_W-1:0]   ct_q, ct_d;
  logic [CH_W-1:0]   cur_ch_q, cur_ch_d;
  logic [CH_W-1:0]   tag_q, tag_d;
  logic [3:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       msg_cnt_q, msg_cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [7:0]        data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef AES_SCHED_TIMEOUT_EN
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYC - 1);
  logic              err_q, err_d;
  logic [15:0]       wdog_q, wdog_d;
`endif

  logic            arb_take;
  logic            pick_vld;
  logic [CH_W-1:0] pick_idx;

  // The run-length check in ARB has priority, so no grant is taken then.
  assign arb_take = (state_q == ST_ARB) && (msg_cnt_q != 32'(MAX_NUM)) && pick_vld;

  rr_arbiter #(.NREQ(NREQ), .CH_W(CH_W)) u_arb (
    .clk      (clk),
    .rst_h    (rst_h),
    .req      (bus.req),
    .upd      (arb_take),
    .pick_vld (pick_vld),
    .pick_idx (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = '0;
    core_load_d = 1'b0;
    pt_d        = pt_q;
    ct_d        = ct_q;
    cur_ch_d    = cur_ch_q;
    tag_d       = tag_q;
    byte_idx_d  = byte_idx_q;
    msg_cnt_d   = msg_cnt_q;
    wr_en_d     = 1'b0;
    data_d      = data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef AES_SCHED_TIMEOUT_EN
    err_d       = err_q;
    wdog_d      = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_ARB;
          msg_cnt_d = '0;
          busy_d    = 1'b1;
`ifdef AES_SCHED_TIMEOUT_EN
          err_d     = 1'b0;
`endif
        end
      end
      ST_ARB: begin
        if (msg_cnt_q == 32'(MAX_NUM)) begin
          state_d = ST_STOP;
        end else if (pick_vld) begin
          gnt_d       = NREQ'(1) << pick_idx;
          pt_d        = bus.pt_in[PT_W*int'(pick_idx) +: PT_W];
          cur_ch_d    = pick_idx;
          // Raised here so the strobe is high for the whole LOAD cycle.
          core_load_d = 1'b1;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_ENC;
      ST_ENC: begin
        if (bus.core_rdy) begin
          ct_d       = bus.core_ct;
          byte_idx_d = '0;
          state_d    = ST_SEND;
        end
`ifdef AES_SCHED_TIMEOUT_EN
        else if (wdog_q == WDOG_LAST) begin
          err_d     = 1'b1;
          msg_cnt_d = msg_cnt_q + 32'd1;
          state_d   = ST_ARB;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
`endif
      end
      ST_SEND: begin
        // byte_idx only advances on an accepted write, so a stall neither
        // drops nor repeats a byte.
        if (!bus.fifo_afull) begin
          wr_en_d    = 1'b1;
          data_d     = ct_q[8*byte_idx_q +: 8];
          tag_d      = cur_ch_q;
          byte_idx_d = byte_idx_q + 4'd1;
          if (byte_idx_q == 4'(BYTES_PER_MSG - 1)) begin
            msg_cnt_d = msg_cnt_q + 32'd1;
            state_d   = ST_ARB;
          end
        end
      end
      ST_STOP: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_h) begin
    if (rst_h) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      core_load_q <= 1'b0;
      pt_q        <= '0;
      ct_q        <= '0;
      cur_ch_q    <= '0;
      tag_q       <= '0;
      byte_idx_q  <= '0;
      msg_cnt_q   <= '0;
      wr_en_q     <= 1'b0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef AES_SCHED_TIMEOUT_EN
      err_q       <= 1'b0;
      wdog_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      core_load_q <= core_load_d;
      pt_q        <= pt_d;
      ct_q        <= ct_d;
      cur_ch_q    <= cur_ch_d;
      tag_q       <= tag_d;
      byte_idx_q  <= byte_idx_d;
      msg_cnt_q   <= msg_cnt_d;
      wr_en_q     <= wr_en_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef AES_SCHED_TIMEOUT_EN
      err_q       <= err_d;
      wdog_q      <= wdog_d;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.core_load = core_load_q;
  assign bus.core_pt   = pt_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.data_out  = data_q;
  assign bus.tag_out   = tag_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
`ifdef AES_SCHED_TIMEOUT_EN
  assign bus.err_timeout = err_q;
`else
  assign bus.err_timeout = 1'b0;
`endif
endmodule
